// File: rtl/cpu_trace_fifo.sv
// Trace FIFO capturing CPU {opcode, PC, ALU result} samples with overflow accounting.
// Optional macro TRACE_PC_CHANGE_FILTER_EN logs only samples whose PC differs from the previous one.
module cpu_trace_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Capture,
  input  logic [31:0]       PCIN,
  input  logic [31:0]       ALUIN,
  input  logic [5:0]        OPIN,
  input  logic              RdReady,
  input  logic              ClrOvf,
  output logic              RdValid,
  output logic [69:0]       RdData,
  output logic [ADDR_W:0]   Count,
  output logic              Full,
  output logic              Empty,
  output logic              Overflow,
  output logic [15:0]       DropCnt
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [69:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic              overflow_q;
  logic [15:0]       drop_cnt;
  logic              sample;
  logic              push;
  logic              pop;
  logic              drop;

`ifdef TRACE_PC_CHANGE_FILTER_EN
  logic [31:0] prev_pc;
  logic        first;

  assign sample = Capture && (first || (PCIN != prev_pc));

  // prev_pc tracks every enabled cycle, even when the sample itself is dropped
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      prev_pc <= '0;
      first   <= 1'b1;
    end else if (Capture) begin
      prev_pc <= PCIN;
      first   <= 1'b0;
    end else begin
      first   <= 1'b1;
    end
  end
`else
  assign sample = Capture;
`endif

  assign Empty    = (count_q == '0);
  assign Full     = (count_q == FULL_CNT);
  assign RdValid  = !Empty;
  assign pop      = RdValid && RdReady;
  assign push     = sample && (!Full || pop);
  assign drop     = sample && Full && !pop;
  assign Count    = count_q;
  assign Overflow = overflow_q;
  assign DropCnt  = drop_cnt;
  assign RdData   = mem[rd_ptr];

  // Storage is intentionally not reset; RdData is meaningless while empty
  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wr_ptr] <= {OPIN, PCIN, ALUIN};
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // A clear in the same cycle as a drop wins
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      overflow_q <= 1'b0;
      drop_cnt   <= '0;
    end else if (ClrOvf) begin
      overflow_q <= 1'b0;
      drop_cnt   <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_trace_fifo.sv
// Self-checking bench for cpu_trace_fifo: directed steps plus random traffic against a queue model.
module tb_cpu_trace_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              Capture;
  logic [31:0]       PCIN;
  logic [31:0]       ALUIN;
  logic [5:0]        OPIN;
  logic              RdReady;
  logic              ClrOvf;
  logic              RdValid;
  logic [69:0]       RdData;
  logic [ADDR_W:0]   Count;
  logic              Full;
  logic              Empty;
  logic              Overflow;
  logic [15:0]       DropCnt;

  int checks   = 0;
  int failures = 0;

  logic [69:0] q [$];
  logic        m_ovf;
  logic [15:0] m_drop;
`ifdef TRACE_PC_CHANGE_FILTER_EN
  logic [31:0] m_prev;
  logic        m_first;
`endif

  cpu_trace_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Reset(Reset), .Capture(Capture), .PCIN(PCIN), .ALUIN(ALUIN),
    .OPIN(OPIN), .RdReady(RdReady), .ClrOvf(ClrOvf), .RdValid(RdValid),
    .RdData(RdData), .Count(Count), .Full(Full), .Empty(Empty),
    .Overflow(Overflow), .DropCnt(DropCnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_drop = '0;
`ifdef TRACE_PC_CHANGE_FILTER_EN
    m_prev  = '0;
    m_first = 1'b1;
`endif
  endtask

  // One clock of the reference behaviour, using the inputs present at the edge
  task automatic model_step();
    logic s;
    logic dropped;
    s = Capture;
`ifdef TRACE_PC_CHANGE_FILTER_EN
    s = Capture && (m_first || PCIN != m_prev);
    if (Capture) begin
      m_prev  = PCIN;
      m_first = 1'b0;
    end else begin
      m_first = 1'b1;
    end
`endif
    dropped = 1'b0;
    if (q.size() != 0 && RdReady) void'(q.pop_front());
    if (s) begin
      if (q.size() < DEPTH) q.push_back({OPIN, PCIN, ALUIN});
      else dropped = 1'b1;
    end
    if (ClrOvf) begin
      m_ovf  = 1'b0;
      m_drop = '0;
    end else if (dropped) begin
      m_ovf = 1'b1;
      if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 70'(Count), 70'(q.size()));
    chk({tag, ".empty"}, 70'(Empty), 70'(q.size() == 0));
    chk({tag, ".full"}, 70'(Full), 70'(q.size() == DEPTH));
    chk({tag, ".rdvalid"}, 70'(RdValid), 70'(q.size() != 0));
    chk({tag, ".overflow"}, 70'(Overflow), 70'(m_ovf));
    chk({tag, ".dropcnt"}, 70'(DropCnt), 70'(m_drop));
    if (q.size() != 0) chk({tag, ".rddata"}, RdData, q[0]);
  endtask

  task automatic cycle(input string tag);
    @(posedge Clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic cap, input logic [31:0] pc, input logic rdy, input logic clr);
    Capture = cap;
    PCIN    = pc;
    ALUIN   = pc ^ 32'hA5A5_0000;
    OPIN    = pc[7:2];
    RdReady = rdy;
    ClrOvf  = clr;
  endtask

  initial begin
    int n_filter;
    Reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    model_reset();
    #50;
    check_all("reset");
    #50;
    Reset = 1'b1;

    // first record
    Capture = 1'b1; PCIN = 32'h4; ALUIN = 32'h10; OPIN = 6'h08;
    cycle("first");
    chk("first.rddata_const", RdData, 70'h08_00000004_00000010);
    chk("first.count_const", 70'(Count), 70'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    cycle("first_drain");

    // fill to full and overflow
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
      cycle("fill");
    end
    chk("fill.full_const", 70'(Full), 70'd1);
    chk("fill.ovf_const", 70'(Overflow), 70'd1);
    chk("fill.drop_const", 70'(DropCnt), 70'd4);

    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      #0;
      chk("drain.pc_order", 70'(RdData[63:32]), 70'(i * 4));
      cycle("drain");
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    cycle("empty_ready");
    chk("empty_ready.count_const", 70'(Count), 70'd0);

    // refill, then simultaneous push and pop while full
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0);
      cycle("refill");
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h200 + 32'(i * 4), 1'b1, 1'b0);
      #0;
      chk("pushpop.head_pc", 70'(RdData[63:32]), 70'(32'h100 + 32'(i * 4)));
      cycle("pushpop");
      chk("pushpop.count_const", 70'(Count), 70'd16);
      chk("pushpop.drop_const", 70'(DropCnt), 70'd4);
    end

    // clear wins over a simultaneous drop
    drive(1'b1, 32'h300, 1'b0, 1'b1);
    cycle("clr_vs_drop");
    chk("clr_vs_drop.ovf_const", 70'(Overflow), 70'd0);
    chk("clr_vs_drop.drop_const", 70'(DropCnt), 70'd0);

    // PC repeat sequence
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      cycle("pre_filter_drain");
    end
    begin
      logic [31:0] seq [6];
      seq = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h4, 32'h8};
      for (int i = 0; i < 6; i++) begin
        drive(1'b1, seq[i], 1'b0, 1'b0);
        cycle("filter_seq");
      end
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    cycle("filter_idle");
`ifdef TRACE_PC_CHANGE_FILTER_EN
    n_filter = 3;
`else
    n_filter = 6;
`endif
    chk("filter.count_const", 70'(Count), 70'(n_filter));
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      cycle("filter_drain");
    end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 32'($urandom_range(0, 3) * 4),
            $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
      ALUIN = $urandom;
      OPIN  = 6'($urandom_range(0, 63));
      cycle("random");
    end

    // mid-stream asynchronous reset
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      cycle("pre_reset_drain");
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h400 + 32'(i * 4), 1'b0, 1'b0);
      cycle("pre_reset_fill");
    end
    chk("pre_reset.count_const", 70'(Count), 70'd5);
    #2;
    Reset = 1'b0;
    #1;
    chk("async_reset.count", 70'(Count), 70'd0);
    chk("async_reset.empty", 70'(Empty), 70'd1);
    chk("async_reset.rdvalid", 70'(RdValid), 70'd0);
    model_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;
    drive(1'b1, 32'h500, 1'b0, 1'b0);
    cycle("post_reset_push");
    chk("post_reset.count_const", 70'(Count), 70'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_trace_fifo.md
# cpu_trace_fifo

- Debug trace buffer directly downstream of the CPU core.
- Samples the core's per-cycle observation outputs: program counter, ALU result and current opcode.
- Stores the samples as 70-bit trace records in a FIFO, which a host or monitor drains through a valid/ready read port.
- Reports overflow and counts dropped samples so traces can be trusted or discarded.

## Interface

Parameters:
- DEPTH, 16, number of trace records; power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH).

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Capture  in  1  trace enable; sampling only while high.
- PCIN  in  32  core program counter (PCOUT of CPU).
- ALUIN  in  32  core ALU result (ALUOUT of CPU).
- OPIN  in  6  core current opcode (CURROP of CPU).
- RdReady  in  1  consumer accepts the head record this cycle.
- ClrOvf  in  1  synchronous clear of Overflow and DropCnt.
- RdValid  out  1  head record available.
- RdData  out  70  head record {OP[69:64], PC[63:32], ALU[31:0]}.
- Count  out  ADDR_W+1  records held, 0..DEPTH.
- Full  out  1  Count == DEPTH.
- Empty  out  1  Count == 0.
- Overflow  out  1  sticky; set when a sample was dropped.
- DropCnt  out  16  dropped-sample count, saturating at 16'hFFFF.

## Operation

- Reset low, asynchronously:
  - pointers and Count go to 0; Empty=1, Full=0, RdValid=0.
  - Overflow=0, DropCnt=0.
  - RdData is don't-care (array not cleared).
- Sample condition S = Capture. This is unfiltered behaviour; see Configuration.
- Push occurs when S && (!Full || pop):
  - writes {OPIN, PCIN, ALUIN} at wr_ptr;
  - wr_ptr increments modulo DEPTH.
- Pop occurs when RdValid && RdReady:
  - rd_ptr increments modulo DEPTH.
- Count: +1 on push only, −1 on pop only, unchanged on both or neither.
- RdValid = !Empty. RdData = mem[rd_ptr], read asynchronously from the registered array.
- The RdData record is held stable while RdValid && !RdReady.
- Full with simultaneous pop:
  - the push is accepted;
  - Count stays DEPTH;
  - nothing is dropped.
- Drop occurs when S && Full && !pop:
  - the record is discarded;
  - Overflow is set;
  - DropCnt increments, saturating at 16'hFFFF.
- ClrOvf:
  - clears Overflow and DropCnt next edge;
  - if a drop occurs in the same cycle, the clear wins: Overflow=0, DropCnt=0.
- Empty with RdReady high is harmless: no pop, and pointers are unchanged.
- Pointer wrap is silent. Full/Empty are derived from Count, never from pointer equality alone.

## Timing

- Write-to-read latency: 1 cycle.
  - A record pushed at edge N gives RdValid=1 and valid RdData after edge N.
- Pop takes effect at the edge. The next record appears on RdData after that edge; this is combinational from rd_ptr.
- Sustained push+pop gives 1 record per cycle throughput.
- Count, Full, Empty, Overflow and DropCnt are all registered. Each reflects the edge just taken.
- Reset assertion mid-stream:
  - immediately discards all contents;
  - records pushed in the same cycle are lost.
- Deassertion is synchronised externally; the first push is possible on the first edge with Reset high.

## Configuration

- Macro: TRACE_PC_CHANGE_FILTER_EN.
- Defined:
  - an internal prev_pc register and first flag are added, reset to 0 and 1 respectively;
  - S = Capture && (first || PCIN != prev_pc);
  - prev_pc <= PCIN every cycle Capture is high, including dropped samples;
  - first clears after the first cycle with Capture high, and sets again when Capture is low;
  - effect: one record per distinct instruction fetch, so stalls and repeated PCs are not logged.
- Undefined: S = Capture, and one record is taken every enabled cycle.

## Test plan

- **Reset and first record.** Hold Reset low 100 ns, release. Then Capture=1 for one cycle with PC=32'h4, ALU=32'h10, OP=6'h08.
  - Required: RdValid=1 next cycle, RdData=70'h08_00000004_00000010, Count=1.
- **Fill to full, then overflow.** Capture=1 for 20 cycles with RdReady=0 and PC incrementing by 4.
  - Required: Full after 16 pushes; Overflow=1; DropCnt=4.
  - Drain: the records come out in PC order 0x0..0x3C.
- **Full with simultaneous push and pop.** When full, hold Capture=1 and RdReady=1 for 8 cycles.
  - Required: Count stays 16, DropCnt unchanged, records stay in strict order.
- **Clear versus drop.** Full, Capture=1, RdReady=0, ClrOvf=1 in the same cycle.
  - Required: Overflow=0 and DropCnt=0 after the edge.
- **Filter on.** Build with TRACE_PC_CHANGE_FILTER_EN. Drive PC sequence 0,0,0,4,4,8 with Capture=1.
  - Required: exactly 3 records, PCs 0, 4, 8.
  - Without the macro: 6 records.
- **Mid-stream reset.** Five records held, drive Reset low asynchronously between edges.
  - Required: Count=0, Empty=1, RdValid=0 immediately, with no clock edge needed.
